// File: rtl/fetch_pkg.sv
// Shared defaults and the fetch-queue entry type for the fetch stage.
// The optional FETCH_PERF_EN counters are configured in fetch_unit.
package fetch_pkg;

    localparam int DEF_PC_W        = 8;
    localparam int DEF_INSTR_W     = 16;
    localparam int DEF_PC_INC      = 4;
    localparam int DEF_QUEUE_DEPTH = 4;
    localparam int DEF_RESET_PC    = 0;

    // Entry layout at default widths; fetch_unit builds a matching type for its own widths.
    typedef struct packed {
        logic [DEF_PC_W-1:0]    pc;
        logic [DEF_INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Occupancy counters need one bit more than the pointers to represent "full".
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetch entries (pc + instr) with push, pop, flush and occupancy count.
// The head entry is read combinationally so decode sees it in the same cycle it is counted.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = DEF_QUEUE_DEPTH,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          push,
    input  entry_t                        push_data,
    input  logic                          pop,
    output entry_t                        head,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = count_width(DEPTH);

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   head_reg;
    logic [PTR_W-1:0]   tail_reg;
    logic [CNT_W-1:0]   count_reg;

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[tail_reg] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally at their width.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + PTR_W'(1);
            end
            if (pop) begin
                head_reg <= head_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head  = mem[head_reg];
    assign count = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch into a small queue with redirect flush; 1-cycle ROM latency.
// Define FETCH_PERF_EN to add saturating perf_fetched / perf_flushed counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_W        = DEF_PC_W,
    parameter int INSTR_W     = DEF_INSTR_W,
    parameter int PC_INC      = DEF_PC_INC,
    parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH,
    parameter int RESET_PC    = DEF_RESET_PC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_flushed
`endif
);

    localparam int CNT_W = count_width(QUEUE_DEPTH);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [PC_W-1:0]  pc_reg;
    logic [PC_W-1:0]  rsp_pc_reg;
    logic             inflight_reg;

    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   occupancy;
    entry_t           head;
    entry_t           push_data;
    logic             push;
    logic             pop;
    logic             space;

    // A redirect hides the head and suppresses any pop in the same cycle.
    assign out_valid = (count != '0) && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign push      = inflight_reg && !redirect_valid;

    // Count the outstanding read as occupied so a response can never land in a full queue.
    assign occupancy = {1'b0, count} + (CNT_W + 1)'(inflight_reg) - (CNT_W + 1)'(pop);
    assign space     = occupancy < (CNT_W + 1)'(QUEUE_DEPTH);

    assign imem_req  = !reset && (redirect_valid || space);
    assign imem_addr = redirect_valid ? redirect_pc : pc_reg;

    assign push_data = '{pc: rsp_pc_reg, instr: imem_rdata};
    assign out_pc    = head.pc;
    assign out_instr = head.instr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg       <= PC_W'(RESET_PC);
            rsp_pc_reg   <= '0;
            inflight_reg <= 1'b0;
        end else if (redirect_valid) begin
            // The redirect target is fetched this very cycle, like the old next-PC mux.
            pc_reg       <= redirect_pc + PC_W'(PC_INC);
            rsp_pc_reg   <= redirect_pc;
            inflight_reg <= 1'b1;
        end else if (space) begin
            pc_reg       <= pc_reg + PC_W'(PC_INC);
            rsp_pc_reg   <= pc_reg;
            inflight_reg <= 1'b1;
        end else begin
            inflight_reg <= 1'b0;
        end
    end

    fetch_queue #(
        .DEPTH   (QUEUE_DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

`ifdef FETCH_PERF_EN
    logic [32:0]      fetched_sum;
    logic [32:0]      flushed_sum;
    logic [CNT_W:0]   discarded;

    assign discarded   = {1'b0, count} + (CNT_W + 1)'(inflight_reg);
    assign fetched_sum = {1'b0, perf_fetched} + 33'(pop);
    assign flushed_sum = {1'b0, perf_flushed} + 33'(discarded);

    // Both counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            perf_fetched <= fetched_sum[32] ? 32'hFFFF_FFFF : fetched_sum[31:0];
            if (redirect_valid) begin
                perf_flushed <= flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random ready/redirect traffic
// checked against an in-order PC stream model (next expected head PC and next fetch address).
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_instr;
    logic [7:0]  out_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: stream of PCs decode must see, and the next sequential fetch address.
    logic [7:0]  exp_pc    = 8'h00;
    logic [7:0]  exp_fetch = 8'h00;
    int          pops      = 0;
    logic        last_valid;
    logic        last_req;
    logic [7:0]  last_pc;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed)
`endif
    );

    function automatic logic [15:0] rom(input logic [7:0] a);
        return {8'h00, a} ^ 16'hA5A5;
    endfunction

    // Synchronous ROM, one cycle of read latency.
    always @(posedge clk) imem_rdata <= rom(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check against the model, then let the rising edge happen.
    task automatic cycle(input logic rv, input logic [7:0] rpc, input logic rdy);
        @(negedge clk);
        reset          = 1'b0;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #1;
        last_valid = out_valid;
        last_req   = imem_req;
        last_pc    = out_pc;
        if (rv) begin
            chk("redirect_out_valid", out_valid, 1'b0);
            chk("redirect_req", imem_req, 1'b1);
            chk("redirect_addr", imem_addr, rpc);
            exp_pc    = rpc;
            exp_fetch = rpc + 8'd4;
        end else begin
            if (imem_req) begin
                chk("fetch_addr", imem_addr, exp_fetch);
                exp_fetch = exp_fetch + 8'd4;
            end
            if (out_valid) begin
                chk("head_pc", out_pc, exp_pc);
                chk("head_instr", out_instr, rom(exp_pc));
                if (rdy) begin
                    $display("pop pc=%02h instr=%04h", out_pc, out_instr);
                    exp_pc = exp_pc + 8'd4;
                    pops++;
                end
            end
        end
    endtask

    initial begin
        int start_pops;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_req", imem_req, 1'b0);

        // Reset release: first head at cycle 2, then one per cycle
        cycle(1'b0, 8'h00, 1'b1);
        chk("rst_c0_valid", last_valid, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        chk("rst_c1_valid", last_valid, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        chk("rst_c2_valid", last_valid, 1'b1);
        chk("rst_c2_pc", last_pc, 8'h00);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            chk("throughput_valid", last_valid, 1'b1);
        end

        // Back-pressure: queue fills, issue stops, drain resumes in order
        cycle(1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b0);
        chk("full_req", last_req, 1'b0);
        chk("full_valid", last_valid, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("drain_progress", exp_pc, 8'h20);

        // Redirect with 3 queued entries plus one in flight
        cycle(1'b1, 8'h80, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0);
        chk("three_queued_req", last_req, 1'b1);
        cycle(1'b1, 8'h40, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        chk("redir_n1_valid", last_valid, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        chk("redir_n2_valid", last_valid, 1'b1);
        chk("redir_n2_pc", last_pc, 8'h40);

        // PC wrap
        cycle(1'b1, 8'hFC, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        chk("wrap_pc0", last_pc, 8'hFC);
        cycle(1'b0, 8'h00, 1'b1);
        chk("wrap_pc1", last_pc, 8'h00);
        cycle(1'b0, 8'h00, 1'b1);
        chk("wrap_pc2", last_pc, 8'h04);

        // Back-to-back redirects
        cycle(1'b1, 8'h10, 1'b1);
        cycle(1'b1, 8'h20, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        chk("b2b_n1_valid", last_valid, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        chk("b2b_valid", last_valid, 1'b1);
        chk("b2b_pc", last_pc, 8'h20);

        // Random ready / redirect traffic against the stream model
        start_pops = pops;
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 16) == 0, 8'($urandom), ($urandom % 4) != 0);
        end
        chk("random_made_progress", 32'(pops > start_pops + 100), 32'd1);

`ifdef FETCH_PERF_EN
        @(posedge clk);
        #1;
        chk("perf_fetched", perf_fetched, 32'(pops));
`endif

        // Asynchronous reset mid-stream with the queue full
        for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b0);
        chk("pre_reset_full_valid", last_valid, 1'b1);
        chk("pre_reset_full_req", last_req, 1'b0);
        @(negedge clk);
        out_ready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_valid", out_valid, 1'b0);
        chk("async_reset_req", imem_req, 1'b0);
        repeat (2) @(posedge clk);
        #1;
`ifdef FETCH_PERF_EN
        chk("perf_fetched_reset", perf_fetched, 32'd0);
        chk("perf_flushed_reset", perf_flushed, 32'd0);
`endif
        exp_pc    = 8'h00;
        exp_fetch = 8'h00;
        pops      = 0;
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        chk("post_reset_valid", last_valid, 1'b1);
        chk("post_reset_pc", last_pc, 8'h00);
        cycle(1'b0, 8'h00, 1'b1);
        chk("post_reset_pc1", last_pc, 8'h04);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised successor to the single-cycle fetch stage. Holds the PC and issues one sequential instruction-memory read per cycle to a synchronous ROM with 1-cycle read latency. Buffers returned instructions with their PC in a small FIFO and hands them to decode over a valid/ready handshake. A redirect from execute/branch logic flushes everything in flight and restarts fetch at the redirect target.

Parameters:
PC_W, 8, PC / instruction address width in bits
INSTR_W, 16, instruction width in bits
PC_INC, 4, sequential PC increment; arithmetic is modulo 2^PC_W
QUEUE_DEPTH, 4, fetch-queue entries; power of 2, minimum 2
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
redirect_valid  in  1  load new PC and flush the pipeline this cycle
redirect_pc  in  PC_W  redirect target
imem_req  out  1  read strobe to instruction ROM
imem_addr  out  PC_W  read address
imem_rdata  in  INSTR_W  ROM data; valid the cycle after imem_req
out_valid  out  1  queue head holds a valid instruction
out_ready  in  1  decode accepts the head this cycle
out_instr  out  INSTR_W  head instruction
out_pc  out  PC_W  PC of head instruction

Behaviour:
- State: pc_q (next fetch address), inflight_q with rsp_pc_q (outstanding read and its PC), FIFO with count 0..QUEUE_DEPTH.
- Reset, asynchronous: pc_q=RESET_PC, inflight_q=0, count=0, out_valid=0, imem_req=0 while reset is high.
- Issue: space = (count + inflight_q - pop) < QUEUE_DEPTH, where pop = out_valid & out_ready.
- When no redirect and space is true: imem_req=1, imem_addr=pc_q, pc_q <= pc_q+PC_INC (wraps), inflight_q<=1, rsp_pc_q<=pc_q.
- When space is false: imem_req=0, pc_q holds, inflight_q<=0.
- Response: if inflight_q=1 and no redirect, {rsp_pc_q, imem_rdata} is pushed at this edge.
- Redirect (highest priority):
  - FIFO cleared; an in-flight response is discarded; pop is suppressed and out_valid is forced 0 this cycle.
  - Issue is bypassed, matching the legacy next-PC mux: imem_req=1, imem_addr=redirect_pc, pc_q <= redirect_pc+PC_INC, rsp_pc_q<=redirect_pc, inflight_q<=1.
- Latency: a redirect in cycle N gives out_valid with out_pc=redirect_pc in cycle N+2. The first fetch after reset release appears at N+2 likewise.
- Throughput: 1 instruction/cycle sustained while out_ready=1.
- Simultaneous push and pop: allowed at any count, count unchanged. The space rule guarantees push never hits a full FIFO.
- Full: with count=QUEUE_DEPTH and no pop, issue stops; a pop in the same cycle reopens issue combinationally.
- Empty: out_valid=0; out_instr/out_pc are don't-care.
- out_instr/out_pc remain stable while out_valid=1 and out_ready=0.
- Reset mid-operation clears all state; the pending ROM response is ignored.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs perf_fetched (32-bit count of accepted pops) and perf_flushed (32-bit count of entries plus in-flight responses discarded by redirects). Both are saturating, reset to 0.
- Undefined: these ports and their counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg: fetch_entry_t packed struct {pc, instr}, parametrised via localparams; default widths and RESET_PC constant.
- Sub-module fetch_queue: circular FIFO of fetch_entry_t with push, pop, flush, count. Depth parameter; head/tail pointers wrap modulo QUEUE_DEPTH.
- fetch_unit contains the PC, issue/space logic, redirect and response tracking.

Test Plan:
- Reset release with out_ready=1 and ROM[a]=a^16'hA5A5 -> imem_addr 0,4,8,... from cycle 0; out_pc 0,4,8,... from cycle 2, one per cycle, correct data.
- out_ready=0 for 10 cycles -> count reaches 4, imem_req drops. Raising out_ready drains PCs 0..12 in order with no duplicate or loss, then fetch resumes at 16.
- Redirect to 8'h40 with queue holding 3 entries plus 1 in flight -> out_valid=0 that cycle; next out_pc=8'h40 two cycles later; no stale PC ever appears.
- PC wrap: redirect to 8'hFC -> out_pc sequence FC, 00, 04.
- Back-to-back redirects 8'h10 then 8'h20 -> 8'h10 instruction never delivered; first output is 8'h20.
- Assert reset mid-stream with queue full -> out_valid=0 immediately (async); after release, fetch restarts at RESET_PC. With FETCH_PERF_EN, counters read 0.
